pcileech_tx_gearbox: RTL

PCILEECH_TX_GEARBOX -- requirements
Module: pcileech_tx_gearbox

---
 rtl/pcileech_tx_gearbox_if.sv | 23 ++
 rtl/pcileech_tx_gearbox.sv | 131 +++++++++++++
 2 files changed

// File: rtl/pcileech_tx_gearbox_if.sv
// Valid/ready bundle between the per-channel word sources,
// the TX gearbox and the FT601 TX FIFO.
interface pcileech_tx_gearbox_if #(
  parameter int NUM_CH = 2,
  parameter int IN_W   = 256
);
  logic [NUM_CH*IN_W-1:0] in_data;
  logic [NUM_CH-1:0]      in_valid;
  logic [NUM_CH-1:0]      in_ready;
  logic [31:0]            out_data;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/pcileech_tx_gearbox.sv
// Round-robin N-channel wide-word to 32-bit gearbox that prefixes
// each burst after an idle gap with a MAGIC_WORD preamble.
module pcileech_tx_gearbox #(
  parameter int          NUM_CH     = 2,
  parameter int          IN_W       = 256,
  parameter int          MAGIC_CNT  = 5,
  parameter logic [31:0] MAGIC_WORD = 32'h66665555,
  parameter int          IDLE_CYC   = 16,
  localparam int         CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  pcileech_tx_gearbox_if.slave bus,
  output logic [CW-1:0]       cur_ch,
  output logic [15:0]         stat_bursts
);

  localparam int         BEATS    = IN_W / 32;
  localparam logic [4:0] BLAST    = 5'(BEATS - 1);
  localparam logic [3:0] PLAST    = 4'(MAGIC_CNT - 1);
  localparam logic [7:0] IDLE_MAX = 8'(IDLE_CYC);

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    SHIFT
  } state_t;

  state_t          state;
  logic [IN_W-1:0] sreg;
  logic [4:0]      beat;
  logic [3:0]      pcnt;
  logic [7:0]      idle_cnt;
  logic            burst_arm;
  logic            live;
  logic [CW-1:0]   last_grant;
  logic [CW-1:0]   gnt;
  logic            gnt_vld;
  logic            cap;
  logic            acc;

  // Lowest distance after last_grant wins: scan far-to-near so
  // the nearest valid channel is the last assignment.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (bus.in_valid[(int'(last_grant) + k) % NUM_CH]) begin
        gnt     = CW'((int'(last_grant) + k) % NUM_CH);
        gnt_vld = 1'b1;
      end
    end
  end

  assign cap = live && (state == IDLE) && gnt_vld;
  assign acc = bus.out_valid && bus.out_ready;

  always_comb begin
    bus.in_ready = '0;
    if (cap) bus.in_ready[gnt] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      sreg          <= '0;
      beat          <= '0;
      pcnt          <= '0;
      idle_cnt      <= '0;
      burst_arm     <= 1'b1;
      live          <= 1'b0;
      last_grant    <= CW'(NUM_CH - 1);
      cur_ch        <= '0;
      stat_bursts   <= '0;
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      live <= 1'b1;
      unique case (state)
        IDLE: begin
          if (cap) begin
            sreg          <= bus.in_data[int'(gnt)*IN_W +: IN_W];
            cur_ch        <= gnt;
            last_grant    <= gnt;
            idle_cnt      <= '0;
            beat          <= '0;
            pcnt          <= '0;
            bus.out_valid <= 1'b1;
            if (burst_arm && (MAGIC_CNT > 0)) begin
              state        <= PREAMBLE;
              bus.out_data <= MAGIC_WORD;
            end else begin
              state        <= SHIFT;
              bus.out_data <= bus.in_data[int'(gnt)*IN_W +: 32];
            end
          end else if (idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + 8'd1;
            if (idle_cnt + 8'd1 == IDLE_MAX) burst_arm <= 1'b1;
          end
        end
        PREAMBLE: begin
          if (acc) begin
            if (pcnt == PLAST) begin
              burst_arm    <= 1'b0;
              stat_bursts  <= stat_bursts + 16'd1;
              state        <= SHIFT;
              bus.out_data <= sreg[31:0];
            end else begin
              pcnt <= pcnt + 4'd1;
            end
          end
        end
        SHIFT: begin
          if (acc) begin
            if (beat == BLAST) begin
              state         <= IDLE;
              bus.out_valid <= 1'b0;
              bus.out_data  <= '0;
            end else begin
              beat         <= beat + 5'd1;
              sreg         <= sreg >> 32;
              bus.out_data <= sreg[63:32];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
